// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
//   Multi-channel debounce filter for mechanical buttons and switches.
//   Each raw input is brought into the clock domain by a 2-flop synchroniser.
//   A single prescaler shared by all channels produces a one-cycle tick, and
//   each channel accepts a new level only after DEBOUNCE_TICKS consecutive
//   ticks of a stable, different synchronised level. The channel output can
//   be bypassed to the synchronised raw level. Rise and fall pulses follow
//   the selected output.
//
//   Optional feature (macro DEBOUNCE_LONG_PRESS_EN):
//     defined   - each channel emits a single-cycle o_Long pulse once it has
//                 been debounced-high for LONG_TICKS ticks
//     undefined - no long counters are built; o_Long is tied to 0
//
// Ports
//   i_Clk     system clock
//   i_Reset   synchronous, active-high reset
//   i_Switch  [NUM_CH] raw asynchronous switch inputs
//   i_Enable  1 = debounced output, 0 = bypass (synchronised raw input)
//   o_Switch  [NUM_CH] filtered (or bypassed) level
//   o_Rise    [NUM_CH] one-cycle pulse on 0->1 of o_Switch
//   o_Fall    [NUM_CH] one-cycle pulse on 1->0 of o_Switch
//   o_Long    [NUM_CH] one-cycle long-press pulse
// ---------------------------------------------------------------------------

// Per-channel filter: stability counter, output mux, edge detect, long press.
module debounce_ch #(
    parameter int   DEBOUNCE_TICKS = 10,
    parameter int   LONG_TICKS     = 1000,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Sync,
    input  logic i_Tick,
    input  logic i_Enable,
    output logic o_Out,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Long
);
    localparam int            CW      = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [CW-1:0] r_Count;
    logic          r_State;
    logic          r_Prev;
    logic          w_Out;

    // Any cycle where the input agrees with the accepted level throws away
    // the progress made so far, so only an uninterrupted run is accepted.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= RESET_LEVEL;
            r_Count <= '0;
        end else if (i_Sync == r_State) begin
            r_Count <= '0;
        end else if (i_Tick) begin
            if (r_Count == DB_LAST) begin
                r_State <= i_Sync;
                r_Count <= '0;
            end else begin
                r_Count <= r_Count + CW'(1);
            end
        end
    end

    // Filter keeps running while bypassed, so re-enabling only produces the
    // edge implied by the difference between r_State and the raw level.
    assign w_Out = i_Enable ? r_State : i_Sync;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) r_Prev <= RESET_LEVEL;
        else         r_Prev <= w_Out;
    end

    assign o_Out  = w_Out;
    assign o_Rise = w_Out & ~r_Prev;
    assign o_Fall = ~w_Out & r_Prev;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int            LW        = $clog2(LONG_TICKS + 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_TICKS);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);

    logic [LW-1:0] r_LongCnt;

    // Saturation at LONG_MAX is what prevents a repeat pulse until the
    // channel is released and the counter clears.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || !r_State) begin
            r_LongCnt <= '0;
        end else if (i_Tick && (r_LongCnt != LONG_MAX)) begin
            r_LongCnt <= r_LongCnt + LW'(1);
        end
    end

    // Pulse on the tick that moves the counter onto LONG_MAX.
    assign o_Long = i_Enable & r_State & i_Tick & (r_LongCnt == LONG_LAST);
`else
    assign o_Long = 1'b0;
`endif
endmodule

module debounce_multi #(
    parameter int   NUM_CH         = 4,
    parameter int   CLKS_PER_TICK  = 25000,
    parameter int   DEBOUNCE_TICKS = 10,
    parameter int   LONG_TICKS     = 1000,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic              i_Enable,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Long
);
    localparam int            PW         = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);

    logic [NUM_CH-1:0] r_Sync1;
    logic [NUM_CH-1:0] r_Sync2;
    logic [PW-1:0]     r_Presc;
    logic              w_Tick;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Sync1 <= {NUM_CH{RESET_LEVEL}};
            r_Sync2 <= {NUM_CH{RESET_LEVEL}};
        end else begin
            r_Sync1 <= i_Switch;
            r_Sync2 <= r_Sync1;
        end
    end

    // With CLKS_PER_TICK == 1 the counter sits at 0 == PRESC_LAST, so the
    // tick is permanently asserted.
    assign w_Tick = (r_Presc == PRESC_LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Reset || w_Tick) r_Presc <= '0;
        else                   r_Presc <= r_Presc + PW'(1);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_ch (
            .i_Clk    (i_Clk),
            .i_Reset  (i_Reset),
            .i_Sync   (r_Sync2[g]),
            .i_Tick   (w_Tick),
            .i_Enable (i_Enable),
            .o_Out    (o_Switch[g]),
            .o_Rise   (o_Rise[g]),
            .o_Fall   (o_Fall[g]),
            .o_Long   (o_Long[g])
        );
    end
endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Multi-channel, tick-prescaled debounce filter for mechanical buttons and switches. It generalises the single-channel debounce with these additions:
- NUM_CH independent channels.
- An input synchroniser.
- A shared millisecond-style prescaler, so per-channel counters stay narrow.
- Rise and fall pulses.
- An optional long-press detector.

It sits between the board pins and the user logic (menus, mode selects, counters).

Parameters:
NUM_CH, 4, number of independent switch channels (>=1)
CLKS_PER_TICK, 25000, clock cycles per prescaler tick (1 ms at 25 MHz); >=1
DEBOUNCE_TICKS, 10, consecutive stable ticks required to accept a new level; >=1
LONG_TICKS, 1000, ticks a debounced-high channel must stay high to flag a long press (used only with the optional feature); >=1
RESET_LEVEL, 1'b0, level loaded into synchroniser, debounced state and edge history at reset

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Switch  in  NUM_CH  raw asynchronous switch inputs
i_Enable  in  1  1 = debounced output; 0 = bypass (synchronised raw input)
o_Switch  out  NUM_CH  filtered (or bypassed) level per channel
o_Rise  out  NUM_CH  one-cycle pulse on 0->1 of o_Switch[n]
o_Fall  out  NUM_CH  one-cycle pulse on 1->0 of o_Switch[n]
o_Long  out  NUM_CH  one-cycle long-press pulse; constant 0 when feature compiled out

Behaviour:
- Reset (i_Reset=1 at a clock edge): sync flops, r_State and edge-history registers take RESET_LEVEL. Channel counters, long counters and prescaler take 0.
- Outputs after reset: o_Switch=RESET_LEVEL, o_Rise=o_Fall=o_Long=0. Reset mid-count discards all progress.
- Synchroniser: 2 flops per channel. w_Sync[n] lags i_Switch[n] by 2 cycles.
- Prescaler: counts 0..CLKS_PER_TICK-1 and wraps. w_Tick=1 for the single cycle where count==CLKS_PER_TICK-1. With CLKS_PER_TICK=1, w_Tick is constantly 1.
- Channel counter width is clog2(DEBOUNCE_TICKS+1). Per channel, each cycle:
  - If w_Sync==r_State: counter <= 0, regardless of tick.
  - Else, if w_Tick: when counter==DEBOUNCE_TICKS-1, r_State <= w_Sync and counter <= 0; otherwise counter++.
  - Else: hold.
- Acceptance delay after w_Sync changes and then stays stable: between (DEBOUNCE_TICKS-1)*CLKS_PER_TICK+1 and DEBOUNCE_TICKS*CLKS_PER_TICK cycles. Any return to r_State level restarts the count.
- Output mux: w_Out[n] = i_Enable ? r_State[n] : w_Sync[n]. The filter keeps running while bypassed, so re-enabling is glitch-free relative to filter state.
- Edge detect: r_Prev <= w_Out each cycle.
  - o_Rise = w_Out & ~r_Prev.
  - o_Fall = ~w_Out & r_Prev.
  - Pulses track o_Switch transitions from any cause, including an i_Enable change when r_State differs from w_Sync.
  - o_Rise and o_Fall are never both high on the same channel.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.

Optional Feature:
Macro DEBOUNCE_LONG_PRESS_EN.
- Defined: each channel has a long counter of width clog2(LONG_TICKS+1).
  - Cleared while r_State==0.
  - While r_State==1, increments on w_Tick and saturates at LONG_TICKS.
  - o_Long[n] pulses for exactly one cycle on the tick where the counter reaches LONG_TICKS.
  - No repeat until the channel is released (r_State returns to 0) and pressed again.
  - o_Long is forced to 0 while i_Enable=0; counting continues underneath.
- Undefined: no long counters are synthesised and o_Long is tied to 0.

Test Plan:
All scenarios use NUM_CH=2, CLKS_PER_TICK=4, DEBOUNCE_TICKS=3, LONG_TICKS=5, RESET_LEVEL=0, and i_Enable=1 unless stated.

1. Reset: assert i_Reset for 3 cycles with i_Switch=2'b11 -> o_Switch=00, no pulses during reset or on the first cycle after it.
2. Clean press: i_Switch=2'b01 held -> o_Switch[0] rises 11..14 cycles after the input edge. Exactly one o_Rise[0] pulse; channel 1 stays 0 with no pulses.
3. Bounce rejection: toggle i_Switch[0] every 5 cycles for 60 cycles, then hold 0 -> o_Switch[0] stays 0, zero pulses. Then hold 1 for 20 cycles -> o_Switch[0]=1 with exactly one o_Rise.
4. Release and reset mid-count:
   - From o_Switch[0]=1, drive 0 -> one o_Fall[0] pulse within 14 cycles.
   - Separately, drive 1 and assert i_Reset 6 cycles later -> o_Switch stays 0 and the count restarts from 0 after reset.
5. Bypass: i_Enable=0 with a 1-cycle high glitch on i_Switch[1] -> o_Switch[1] high for 1 cycle, 2 cycles later, with one o_Rise then one o_Fall. Set i_Enable=1 while r_State != w_Sync -> one matching edge pulse.
6. Long press (macro defined): hold ch0 high for 40 cycles past acceptance -> exactly one o_Long[0] pulse, 5 ticks (17..20 cycles) after acceptance. Release and re-press -> a second pulse. Macro undefined -> o_Long is always 00.
